// File: rtl/ajuste_relogio_pkg.sv
// rtl/ajuste_relogio_pkg.sv - mode encoding, default timing constants and helpers for the time-set controller
package relogio_pkg;

    typedef enum logic [1:0] {
        MODO_RUN   = 2'd0,
        MODO_SET_H = 2'd1,
        MODO_SET_M = 2'd2
    } modo_t;

    // 10 ms debounce, 1 s hold before repeat, 4 Hz repeat, all at 50 MHz
    localparam int DEB_CYCLES_DEF  = 500_000;
    localparam int HOLD_CYCLES_DEF = 50_000_000;
    localparam int REP_CYCLES_DEF  = 12_500_000;

    function automatic logic is_set_mode(input modo_t m);
        return (m == MODO_SET_H) || (m == MODO_SET_M);
    endfunction

endpackage

// File: rtl/ajuste_relogio_if.sv
// rtl/ajuste_relogio_if.sv - button inputs and counter/display control outputs of the time-set controller
interface ajuste_relogio_if;
    import relogio_pkg::*;

    logic  enable_1hz;
    logic  btn_mode;
    logic  btn_inc;
    modo_t modo;
    logic  run_en;
    logic  inc_hora_adj;
    logic  inc_min_adj;
    logic  sec_clear;
    logic  blink_h;
    logic  blink_m;

    modport master (
        output enable_1hz, btn_mode, btn_inc,
        input  modo, run_en, inc_hora_adj, inc_min_adj, sec_clear, blink_h, blink_m
    );

    modport slave (
        input  enable_1hz, btn_mode, btn_inc,
        output modo, run_en, inc_hora_adj, inc_min_adj, sec_clear, blink_h, blink_m
    );

endinterface

// File: rtl/ajuste_relogio_debounce_btn.sv
// rtl/ajuste_relogio_debounce_btn.sv - 2-FF synchronizer, counting debouncer and press-event pulse for one raw button
module debounce_btn
    import relogio_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Synchronize, then let db follow only after DEB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db     <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 != db) begin
                if (cnt == CNT_LAST) begin
                    db   <= sync_2;
                    rise <= sync_2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ajuste_relogio.sv
// rtl/ajuste_relogio.sv - RUN/SET_H/SET_M mode FSM with adjust pulses, auto-repeat and blink masks
module ajuste_relogio
    import relogio_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int REP_CYCLES  = REP_CYCLES_DEF
) (
    input  logic              main_clock,
    input  logic              main_reset,
    ajuste_relogio_if.slave   bus
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYCLES - 1);

    logic db_mode, rise_mode;
    logic db_inc,  rise_inc;
    logic mode_ev, inc_ev;

    modo_t         modo;
    logic          phase;
    logic          inc_hora_adj;
    logic          inc_min_adj;
    logic          sec_clear;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;

    logic hold_full;
    logic hold_hit;
    logic rep_hit;
    logic adj_req;

    debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (main_clock),
        .rst_n (main_reset),
        .raw   (bus.btn_mode),
        .db    (db_mode),
        .rise  (rise_mode)
    );

    debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk   (main_clock),
        .rst_n (main_reset),
        .raw   (bus.btn_inc),
        .db    (db_inc),
        .rise  (rise_inc)
    );

    // A press event is only taken while the settled level agrees with it
    assign mode_ev = rise_mode & db_mode;
    assign inc_ev  = rise_inc  & db_inc;

    // Adjust request: a fresh press, the end of the hold delay, or a repeat period boundary
    always_comb begin
        hold_full = (hold_cnt == HOLD_FULL);
        hold_hit  = db_inc && (hold_cnt == HOLD_LAST);
        rep_hit   = db_inc && hold_full && (rep_cnt == REP_LAST);
        adj_req   = inc_ev | hold_hit | rep_hit;
    end

    // Mode FSM, adjust/clear pulses, hold and repeat counters, blink phase
    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            modo         <= MODO_RUN;
            phase        <= 1'b0;
            inc_hora_adj <= 1'b0;
            inc_min_adj  <= 1'b0;
            sec_clear    <= 1'b0;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
        end else begin
            inc_hora_adj <= 1'b0;
            inc_min_adj  <= 1'b0;
            sec_clear    <= 1'b0;
            if (mode_ev) begin
                // Mode change wins over any inc activity in this cycle
                hold_cnt <= '0;
                rep_cnt  <= '0;
                phase    <= 1'b0;
                case (modo)
                    MODO_RUN:   modo <= MODO_SET_H;
                    MODO_SET_H: modo <= MODO_SET_M;
                    MODO_SET_M: begin
                        modo      <= MODO_RUN;
                        sec_clear <= 1'b1;
                    end
                    default:    modo <= MODO_RUN;
                endcase
            end else if (is_set_mode(modo)) begin
                if (bus.enable_1hz) begin
                    phase <= ~phase;
                end
                if (db_inc) begin
                    if (!hold_full) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end else if (rep_hit) begin
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end else begin
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end
                if (modo == MODO_SET_H) begin
                    inc_hora_adj <= adj_req;
                end else begin
                    inc_min_adj <= adj_req;
                end
            end else begin
                // RUN ignores inc; the unused encoding falls back to RUN
                hold_cnt <= '0;
                rep_cnt  <= '0;
                if (modo != MODO_RUN) begin
                    modo <= MODO_RUN;
                end
            end
        end
    end

    assign bus.modo         = modo;
    assign bus.run_en       = (modo == MODO_RUN);
    assign bus.inc_hora_adj = inc_hora_adj;
    assign bus.inc_min_adj  = inc_min_adj;
    assign bus.sec_clear    = sec_clear;
    assign bus.blink_h      = (modo == MODO_SET_H) & phase;
    assign bus.blink_m      = (modo == MODO_SET_M) & phase;

endmodule

// File: tb/tb_ajuste_relogio.sv
// tb/tb_ajuste_relogio.sv - directed self-checking bench for ajuste_relogio
module tb_ajuste_relogio;
    import relogio_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ajuste_relogio_if bus();

    ajuste_relogio #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .REP_CYCLES  (REP)
    ) dut (
        .main_clock (clk),
        .main_reset (rst_n),
        .bus        (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int n_h  = 0;
    int n_m  = 0;
    int n_sc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n_h  += int'(bus.inc_hora_adj);
        n_m  += int'(bus.inc_min_adj);
        n_sc += int'(bus.sec_clear);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        idle(10);
        bus.btn_mode = 1'b0;
        idle(12);
    endtask

    initial begin
        int h0;
        int m0;
        int k;
        logic [31:0] exp;

        bus.enable_1hz = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;

        // Reset and idle
        idle(3);
        rst_n = 1'b1;
        idle(50);
        chk("rst_modo",    32'(bus.modo), 0);
        chk("rst_run_en",  32'(bus.run_en), 1);
        chk("rst_blink_h", 32'(bus.blink_h), 0);
        chk("rst_blink_m", 32'(bus.blink_m), 0);
        chk("rst_pulses",  32'(n_h + n_m + n_sc), 0);

        // Clean mode press: modo changes exactly 7 cycles after the raw edge
        bus.btn_mode = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) chk("mode_lat6", 32'(bus.modo), 0);
            if (i == 7) begin
                chk("mode_lat7",    32'(bus.modo), 1);
                chk("seth_run_en",  32'(bus.run_en), 0);
            end
        end
        idle(3);
        bus.btn_mode = 1'b0;
        idle(10);

        // Blink phase in SET_H, strobe every 8 cycles
        chk("blink_h_entry", 32'(bus.blink_h), 0);
        for (int s = 0; s < 3; s++) begin
            idle(7);
            bus.enable_1hz = 1'b1;
            tick();
            bus.enable_1hz = 1'b0;
            chk("blink_h_toggle", 32'(bus.blink_h), (s % 2 == 0) ? 1 : 0);
            chk("blink_m_quiet",  32'(bus.blink_m), 0);
        end

        // Bouncy inc press in SET_H gives exactly one hour pulse
        h0 = n_h;
        m0 = n_m;
        bus.btn_inc = 1'b1; idle(2);
        bus.btn_inc = 1'b0; idle(2);
        bus.btn_inc = 1'b1; idle(8);
        bus.btn_inc = 1'b0; idle(15);
        chk("bounce_h_pulses", 32'(n_h - h0), 1);
        chk("bounce_m_pulses", 32'(n_m - m0), 0);
        chk("bounce_modo",     32'(bus.modo), 1);

        // Into SET_M: phase restarts cleared
        press_mode();
        chk("setm_modo",    32'(bus.modo), 2);
        chk("setm_blink_m", 32'(bus.blink_m), 0);
        chk("setm_blink_h", 32'(bus.blink_h), 0);

        // Hold inc 60 cycles in SET_M: event at sample 6, pulses at event+1, +20, +25 ... while db high
        h0 = n_h;
        m0 = n_m;
        bus.btn_inc = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            k = i - 6;
            exp = ((k == 1) || (k >= 20 && k <= 60 && ((k - 20) % 5) == 0)) ? 1 : 0;
            chk("rep_pulse", 32'(bus.inc_min_adj), exp);
            if (i == 60) bus.btn_inc = 1'b0;
        end
        chk("rep_m_total", 32'(n_m - m0), 10);
        chk("rep_h_total", 32'(n_h - h0), 0);

        // SET_M -> RUN: sec_clear and run_en in the same cycle
        bus.btn_mode = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                chk("run_modo",      32'(bus.modo), 0);
                chk("run_sec_clear", 32'(bus.sec_clear), 1);
                chk("run_run_en",    32'(bus.run_en), 1);
                chk("run_blink",     32'({bus.blink_h, bus.blink_m}), 0);
            end
            if (i == 8) chk("run_sec_clear_w", 32'(bus.sec_clear), 0);
        end
        idle(2);
        bus.btn_mode = 1'b0;
        idle(12);
        chk("sec_clear_total", 32'(n_sc), 1);

        // Back to SET_H, then simultaneous mode+inc events
        press_mode();
        chk("sim_pre_modo", 32'(bus.modo), 1);
        h0 = n_h;
        m0 = n_m;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (i == 7)  chk("sim_modo", 32'(bus.modo), 2);
            if (i == 10) bus.btn_mode = 1'b0;
        end
        chk("sim_h_pulses", 32'(n_h - h0), 0);
        chk("sim_m_pulses", 32'(n_m - m0), 2);

        // Asynchronous reset in the middle of auto-repeat
        rst_n = 1'b0;
        #1;
        chk("arst_modo",    32'(bus.modo), 0);
        chk("arst_run_en",  32'(bus.run_en), 1);
        chk("arst_pulses",  32'({bus.inc_hora_adj, bus.inc_min_adj, bus.sec_clear}), 0);
        chk("arst_blink",   32'({bus.blink_h, bus.blink_m}), 0);
        bus.btn_inc = 1'b0;
        idle(3);
        rst_n = 1'b1;
        h0 = n_h;
        m0 = n_m;
        idle(20);
        chk("post_rst_modo",   32'(bus.modo), 0);
        chk("post_rst_pulses", 32'((n_h - h0) + (n_m - m0)), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
